// File: rtl/nes_joypad_port.sv
// rtl/nes_joypad_port.sv - NES standard controller responder (CD4021 emulation) with A/B turbo
module nes_joypad_port #(
    parameter int FREQ     = 37_800_000,
    parameter int FIRERATE = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] buttons,
    input  logic       turbo_a,
    input  logic       turbo_b,
    input  logic       strobe,
    input  logic       read,
    output logic       dout,
    output logic [3:0] count
);

    localparam int DELAY = FREQ / FIRERATE / 2;
    localparam int TW    = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(DELAY - 1);

    logic [TW-1:0] timer;
    logic          phase;
    logic [7:0]    sr;
    logic [7:0]    eff;

    // Free-running autofire oscillator, shared by A and B.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
            phase <= 1'b1;
        end else if (timer == TIMER_LAST) begin
            timer <= '0;
            phase <= ~phase;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    always_comb begin
        eff    = buttons;
        eff[0] = buttons[0] & (~turbo_a | phase);
        eff[1] = buttons[1] & (~turbo_b | phase);
    end

    // Load wins over shift; ones shift in from the top so reads past 8 return 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr    <= 8'h00;
            count <= 4'd0;
        end else if (strobe) begin
            sr    <= eff;
            count <= 4'd0;
        end else if (read) begin
            sr <= {1'b1, sr[7:1]};
            if (count != 4'd8) begin
                count <= count + 4'd1;
            end
        end
    end

    assign dout = sr[0];

endmodule

// File: tb/tb_nes_joypad_port.sv
// tb/tb_nes_joypad_port.sv - self-checking bench for nes_joypad_port
module tb_nes_joypad_port;

    localparam int FREQ     = 100;
    localparam int FIRERATE = 10;
    localparam int DELAY    = FREQ / FIRERATE / 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] buttons = 8'h00;
    logic       turbo_a = 1'b0;
    logic       turbo_b = 1'b0;
    logic       strobe = 1'b0;
    logic       read = 1'b0;
    logic       dout;
    logic [3:0] count;

    int tests = 0;
    int fails = 0;

    // Reference model: byte captured at the last load plus number of reads since.
    int         edges = 0;
    logic [7:0] latched = 8'h00;
    int         n = 0;

    nes_joypad_port #(.FREQ(FREQ), .FIRERATE(FIRERATE)) dut (
        .clk(clk), .reset(reset), .buttons(buttons), .turbo_a(turbo_a), .turbo_b(turbo_b),
        .strobe(strobe), .read(read), .dout(dout), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic phase_at(input int k);
        return ((k / DELAY) % 2) == 0;
    endfunction

    function automatic logic [7:0] eff_of(input logic [7:0] b, input logic ta, input logic tb_, input logic ph);
        logic [7:0] e;
        e = b;
        e[0] = b[0] & (!ta || ph);
        e[1] = b[1] & (!tb_ || ph);
        return e;
    endfunction

    function automatic logic exp_dout();
        return (n < 8) ? latched[n] : 1'b1;
    endfunction

    function automatic logic [3:0] exp_count();
        return (n > 8) ? 4'd8 : 4'(n);
    endfunction

    task automatic step();
        if (!reset) begin
            if (strobe) begin
                latched = eff_of(buttons, turbo_a, turbo_b, phase_at(edges));
                n = 0;
            end else if (read) begin
                if (n < 9) n++;
            end
        end
        @(posedge clk);
        #1;
        if (!reset) edges++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        strobe = 1'b0;
        read = 1'b0;
        step();
        step();
        reset = 1'b0;
        edges = 0;
        latched = 8'h00;
        n = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (dout !== 1'b0 || count !== 4'd0) begin
            fails++;
            $display("FAIL reset_state dout=%b count=%0d required dout=0 count=0", dout, count);
        end
        buttons = 8'($urandom) | 8'h07;
        strobe = 1'b1;
        step();
        strobe = 1'b0;
        read = 1'b1;
        step();
        step();
        read = 1'b0;
        tests++;
        if (dout !== 1'b1 || count !== 4'd2) begin
            fails++;
            $display("FAIL pre_reset dout=%b count=%0d required dout=1 count=2", dout, count);
        end
        #3;
        reset = 1'b1;
        #1;
        tests++;
        if (dout !== 1'b0 || count !== 4'd0) begin
            fails++;
            $display("FAIL async_reset dout=%b count=%0d required dout=0 count=0", dout, count);
        end
        do_reset();
    endtask

    task automatic test_basic_read();
        logic [11:0] want;
        want = 12'b1111_1000_1001;
        turbo_a = 1'b0;
        turbo_b = 1'b0;
        buttons = 8'b1000_1001;
        strobe = 1'b1;
        step();
        step();
        strobe = 1'b0;
        step();
        for (int i = 0; i < 12; i++) begin
            read = 1'b1;
            tests++;
            if (dout !== want[i]) begin
                fails++;
                $display("FAIL basic_read_bit%0d dout=%b required %b", i, dout, want[i]);
            end
            step();
            read = 1'b0;
            tests++;
            if (count !== 4'((i + 1 > 8) ? 8 : i + 1)) begin
                fails++;
                $display("FAIL basic_read_count%0d count=%0d required %0d", i, count, (i + 1 > 8) ? 8 : i + 1);
            end
            if ($urandom_range(0, 1) == 1) step();
        end
        for (int t = 0; t < 6; t++) begin
            buttons = 8'($urandom);
            strobe = 1'b1;
            step();
            strobe = 1'b0;
            buttons = 8'($urandom);
            for (int i = 0; i < 10; i++) begin
                read = 1'b1;
                tests++;
                if (dout !== exp_dout()) begin
                    fails++;
                    $display("FAIL rand_read_t%0d_bit%0d dout=%b required %b", t, i, dout, exp_dout());
                end
                step();
                read = 1'b0;
                tests++;
                if (count !== exp_count()) begin
                    fails++;
                    $display("FAIL rand_read_count t%0d i%0d count=%0d required %0d", t, i, count, exp_count());
                end
            end
        end
    endtask

    task automatic test_strobe_high();
        logic prev;
        strobe = 1'b1;
        turbo_a = 1'b0;
        for (int c = 0; c < 30; c++) begin
            buttons = {7'($urandom), 1'((c / 3) % 2)};
            read = 1'($urandom);
            prev = buttons[0];
            step();
            tests++;
            if (dout !== prev || count !== 4'd0) begin
                fails++;
                $display("FAIL strobe_high_c%0d dout=%b count=%0d required dout=%b count=0", c, dout, count, prev);
            end
        end
        read = 1'b0;
        strobe = 1'b0;
    endtask

    task automatic test_turbo();
        logic want;
        do_reset();
        buttons = 8'h03;
        turbo_a = 1'b1;
        turbo_b = 1'b0;
        strobe = 1'b1;
        for (int i = 0; i < 15; i++) begin
            want = (i < 5 || i >= 10);
            step();
            tests++;
            if (dout !== want) begin
                fails++;
                $display("FAIL turbo_a_cycle%0d dout=%b required %b", i, dout, want);
            end
        end
        for (int j = 0; j < 20; j++) begin
            turbo_b = (j >= 10);
            strobe = 1'b1;
            step();
            strobe = 1'b0;
            read = 1'b1;
            step();
            read = 1'b0;
            want = (j < 10) ? 1'b1 : exp_dout();
            tests++;
            if (dout !== want || count !== 4'd1) begin
                fails++;
                $display("FAIL turbo_b_j%0d dout=%b count=%0d required dout=%b count=1", j, dout, count, want);
            end
        end
        turbo_a = 1'b0;
        turbo_b = 1'b0;
    endtask

    task automatic test_collision();
        logic [7:0] b2;
        buttons = 8'($urandom);
        strobe = 1'b1;
        step();
        strobe = 1'b0;
        read = 1'b1;
        step();
        step();
        step();
        read = 1'b0;
        tests++;
        if (count !== 4'd3) begin
            fails++;
            $display("FAIL collision_partial count=%0d required 3", count);
        end
        b2 = 8'($urandom);
        buttons = b2;
        strobe = 1'b1;
        read = 1'b1;
        step();
        strobe = 1'b0;
        read = 1'b0;
        buttons = ~b2;
        tests++;
        if (count !== 4'd0 || dout !== b2[0]) begin
            fails++;
            $display("FAIL collision_load count=%0d dout=%b required count=0 dout=%b", count, dout, b2[0]);
        end
        for (int i = 0; i < 8; i++) begin
            read = 1'b1;
            tests++;
            if (dout !== b2[i]) begin
                fails++;
                $display("FAIL collision_bit%0d dout=%b required %b", i, dout, b2[i]);
            end
            step();
        end
        read = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 400; c++) begin
            buttons = 8'($urandom);
            turbo_a = 1'($urandom);
            turbo_b = 1'($urandom);
            strobe = ($urandom_range(0, 9) == 0);
            read = 1'($urandom);
            step();
            tests++;
            if (dout !== exp_dout() || count !== exp_count()) begin
                fails++;
                $display("FAIL back_to_back_c%0d dout=%b count=%0d required dout=%b count=%0d",
                         c, dout, count, exp_dout(), exp_count());
            end
        end
        strobe = 1'b0;
        read = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_strobe_high();
        test_turbo();
        test_collision();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
